lift_call_queue: RTL and testbench
==================================

# lift_call_queue

Request-collection stage directly upstream of the 8-floor lift controller. It synchronises and debounces eight raw floor-call buttons and latches them as pending calls. It presents one target floor at a time on `req_floor` using a SCAN (keep-direction) policy, and retires a call when the lift reports the door open at that floor.

## Interface
Parameters:
- `NUM_FLOORS`, 8: number of floors and buttons.
- `FLOOR_W`, 3: floor index width, equal to clog2(`NUM_FLOORS`).
- `DEBOUNCE_CYCLES`, 4: number of consecutive stable synchronised samples required before a level change is accepted (legal range 1..15).

Ports:
- `clk`  input  1  system clock; all logic on the rising edge.
- `reset`  input  1  asynchronous, active-low reset.
- `btn`  input  NUM_FLOORS  raw call buttons, asynchronous, active-high.
- `current_floor`  input  FLOOR_W  lift position fed back from the controller.
- `door_open`  input  1  high while the lift door is open at `current_floor`.
- `emergency_stop`  input  1  freezes target selection and call retirement.
- `req_floor`  output  FLOOR_W  target floor to the lift controller.
- `req_valid`  output  1  `req_floor` holds a real pending call.
- `dir_up`  output  1  current sweep direction: 1 = up, 0 = down.
- `pending`  output  NUM_FLOORS  latched outstanding calls.

## Operation
- Each `btn[i]` passes through a 2-flop synchroniser, then a per-bit debounce counter.
  - The debounced level changes only after `DEBOUNCE_CYCLES` consecutive synchronised samples differ from it.
  - The counter resets on any sample that matches the debounced level.
- A rising edge of the debounced level sets `pending[i]`. Holding a button down does not set it again.
- Call retirement: while `door_open=1` and `emergency_stop=0`, `pending[current_floor]` clears every cycle.
  - If a set and a clear hit the same bit in the same cycle, the clear wins.
- State machine states: IDLE, UP, DOWN.
- IDLE:
  - If `pending` is all zero, stay in IDLE.
  - Otherwise pick the nearest pending floor by absolute distance. Distance is computed as an unsigned FLOOR_W+1-bit difference.
  - On a distance tie, the higher floor wins.
  - Go to UP if the target is at or above `current_floor`, else go to DOWN.
- UP:
  - Target is the lowest pending floor ≥ `current_floor`.
  - If there is none, go to DOWN if any floor below is pending, else go to IDLE.
- DOWN: mirror image of UP (highest pending floor ≤ `current_floor`; turn to UP if only floors above are pending, else IDLE).
- `dir_up` is 1 in UP, 0 in DOWN, and holds its last value in IDLE.
- `req_valid` is 1 exactly when a target was selected. When `req_valid=0`, `req_floor` holds its last value.
- Emergency stop:
  - While `emergency_stop=1`: state, `req_floor`, `req_valid` and `dir_up` are frozen and no call is retired.
  - Button capture continues.
  - After release, normal evaluation resumes on the next edge.
- `current_floor` values ≥ `NUM_FLOORS` are treated as `NUM_FLOORS-1`.

## Timing
- Reset (`reset=0`), asynchronous: `req_floor=0`, `req_valid=0`, `dir_up=0`, `pending=0`, state IDLE, synchronisers and debounce counters cleared, debounced levels 0.
- Reset asserted mid-operation drops all pending calls immediately, with no partial state kept.
- Press latency (edge 1 = first edge sampling `btn=1`, button held stable):
  - `pending[i]` sets after edge 3+`DEBOUNCE_CYCLES`.
  - `req_floor`/`req_valid` reflect it after the following edge.
  - With the default parameters: 7 and 8 cycles.
- `req_floor`, `req_valid` and `dir_up` are registered. They react one cycle after any change in `pending`, `current_floor` or `emergency_stop`.
- No handshake back from the lift: the consumer samples `req_floor` every cycle, and retirement is driven only by `door_open`.

## Configuration
- `LIFT_CALL_DEBOUNCE_EN`
  - Defined: debounce counters are present as described.
  - Undefined: counters are removed and the synchronised level is used directly. Press latency becomes `pending` after edge 3 and `req_*` after edge 4. `DEBOUNCE_CYCLES` is ignored.

## Test plan
- Reset release, then a 2-cycle glitch on `btn[5]` (macro defined, D=4) -> `pending` stays 0x00 and `req_valid` stays 0.
- `current_floor=0`; press `btn[3]` held 10 cycles -> `pending=0x08` after edge 7; `req_floor=3`, `req_valid=1`, `dir_up=1` after edge 8.
- `current_floor=4`, state IDLE; pending floors 2 and 6 set in the same cycle -> tie, so `req_floor=6`, `dir_up=1`.
- Sweep up: `current_floor=2`, UP, floors {1,5} pending; `door_open` asserted at floor 5 -> bit 5 clears; next `req_floor=1`, `dir_up=0`.
- `emergency_stop=1` with `req_floor=5`; press `btn[7]` and assert `door_open` at floor 5 -> `pending[7]` sets, `pending[5]` is kept, `req_floor` stays 5; after release, bit 5 clears and `req_floor=7`.
- Assert `reset=0` with `pending=0xA4` mid-sweep -> all outputs zero in the same cycle, with no waiting for a clock edge.

Source files
------------

// File: rtl/lift_call_queue.sv
// lift_call_queue: synchronises and latches eight floor-call buttons, then issues one SCAN-ordered
// target floor to the lift controller. Option macro: LIFT_CALL_DEBOUNCE_EN (per-button debounce).
module lift_call_queue #(
    parameter int NUM_FLOORS      = 8,
    parameter int FLOOR_W         = 3,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NUM_FLOORS-1:0] btn,
    input  logic [FLOOR_W-1:0]    current_floor,
    input  logic                  door_open,
    input  logic                  emergency_stop,
    output logic [FLOOR_W-1:0]    req_floor,
    output logic                  req_valid,
    output logic                  dir_up,
    output logic [NUM_FLOORS-1:0] pending
);

    typedef enum logic [1:0] {S_IDLE, S_UP, S_DOWN} state_t;

    if (DEBOUNCE_CYCLES < 1 || DEBOUNCE_CYCLES > 15) begin : g_bad_debounce
        $error("DEBOUNCE_CYCLES must be in 1..15");
    end

    logic [NUM_FLOORS-1:0] r_sync1, r_sync2, r_level_d, r_pending;
    logic [NUM_FLOORS-1:0] w_level, w_rise, w_clear;
    logic [FLOOR_W-1:0]    w_cur;

    state_t             r_state, w_state_next;
    logic [FLOOR_W-1:0] r_req_floor, w_tgt;
    logic               r_req_valid, w_valid, r_dir_up, w_dir;

    logic               w_up_found, w_dn_found;
    logic [FLOOR_W-1:0] w_up_tgt, w_dn_tgt, w_near_tgt;
    logic [FLOOR_W:0]   w_near_dist, w_dist;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            // NOTE: non-blocking so r_sync2 takes the old r_sync1; blocking would collapse both stages into one.
            r_sync1 <= btn;
            r_sync2 <= r_sync1;
        end
    end

`ifdef LIFT_CALL_DEBOUNCE_EN
    logic [3:0]            r_cnt [NUM_FLOORS];
    logic [NUM_FLOORS-1:0] r_deb;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            // NOTE: the counter array is reset like any other state so a reset leaves no half-counted press.
            for (int i = 0; i < NUM_FLOORS; i++) r_cnt[i] <= '0;
            r_deb <= '0;
        end else begin
            for (int i = 0; i < NUM_FLOORS; i++) begin
                if (r_sync2[i] == r_deb[i]) begin
                    r_cnt[i] <= '0;
                end else if (r_cnt[i] == 4'(DEBOUNCE_CYCLES - 1)) begin
                    r_deb[i] <= r_sync2[i];
                    r_cnt[i] <= '0;
                end else begin
                    r_cnt[i] <= r_cnt[i] + 4'd1;
                end
            end
        end
    end

    assign w_level = r_deb;
`else
    assign w_level = r_sync2;
`endif

    assign w_rise = w_level & ~r_level_d;
    assign w_cur  = (int'(current_floor) > NUM_FLOORS - 1) ? FLOOR_W'(NUM_FLOORS - 1) : current_floor;

    always_comb begin
        // NOTE: every comb output gets a default first; a missed branch would otherwise infer a latch.
        w_clear = '0;
        if (door_open && !emergency_stop) w_clear[w_cur] = 1'b1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_level_d <= '0;
            r_pending <= '0;
        end else begin
            r_level_d <= w_level;
            r_pending <= (r_pending | w_rise) & ~w_clear;
        end
    end

    // Candidate targets: next call in each sweep direction and the overall nearest (ties go up).
    always_comb begin
        w_up_found  = 1'b0;
        w_up_tgt    = '0;
        w_dn_found  = 1'b0;
        w_dn_tgt    = '0;
        w_near_tgt  = '0;
        w_near_dist = '1;
        w_dist      = '0;
        for (int i = NUM_FLOORS - 1; i >= 0; i--) begin
            if (r_pending[i] && FLOOR_W'(i) >= w_cur) begin
                w_up_found = 1'b1;
                w_up_tgt   = FLOOR_W'(i);
            end
        end
        for (int i = 0; i < NUM_FLOORS; i++) begin
            if (r_pending[i] && FLOOR_W'(i) <= w_cur) begin
                w_dn_found = 1'b1;
                w_dn_tgt   = FLOOR_W'(i);
            end
            if (r_pending[i]) begin
                w_dist = ((FLOOR_W+1)'(i) >= {1'b0, w_cur}) ? (FLOOR_W+1)'(i) - {1'b0, w_cur}
                                                            : {1'b0, w_cur} - (FLOOR_W+1)'(i);
                if (w_dist <= w_near_dist) begin
                    w_near_dist = w_dist;
                    w_near_tgt  = FLOOR_W'(i);
                end
            end
        end
    end

    // A turnaround selects the first call of the new direction in the same cycle, so no bubble.
    always_comb begin
        w_state_next = r_state;
        w_tgt        = r_req_floor;
        w_valid      = 1'b0;
        w_dir        = r_dir_up;
        case (r_state)
            S_IDLE: if (|r_pending) begin
                w_valid = 1'b1;
                w_tgt   = w_near_tgt;
                w_dir   = (w_near_tgt >= w_cur);
                w_state_next = w_dir ? S_UP : S_DOWN;
            end
            S_UP: begin
                if (w_up_found) begin
                    w_valid = 1'b1;
                    w_tgt   = w_up_tgt;
                    w_dir   = 1'b1;
                end else if (w_dn_found) begin
                    w_valid = 1'b1;
                    w_tgt   = w_dn_tgt;
                    w_dir   = 1'b0;
                    w_state_next = S_DOWN;
                end else begin
                    w_state_next = S_IDLE;
                end
            end
            S_DOWN: begin
                if (w_dn_found) begin
                    w_valid = 1'b1;
                    w_tgt   = w_dn_tgt;
                    w_dir   = 1'b0;
                end else if (w_up_found) begin
                    w_valid = 1'b1;
                    w_tgt   = w_up_tgt;
                    w_dir   = 1'b1;
                    w_state_next = S_UP;
                end else begin
                    w_state_next = S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= S_IDLE;
            r_req_floor <= '0;
            r_req_valid <= 1'b0;
            r_dir_up    <= 1'b0;
        end else if (!emergency_stop) begin
            r_state     <= w_state_next;
            r_req_floor <= w_tgt;
            r_req_valid <= w_valid;
            r_dir_up    <= w_dir;
        end
    end

    assign req_floor = r_req_floor;
    assign req_valid = r_req_valid;
    assign dir_up    = r_dir_up;
    assign pending   = r_pending;

endmodule

// File: tb/tb_lift_call_queue.sv
// tb_lift_call_queue: directed scenarios plus randomized traffic, every cycle compared against a
// behavioural model built from raw button history and the SCAN selection rules.
module tb_lift_call_queue;

    localparam int D = 4;
`ifdef LIFT_CALL_DEBOUNCE_EN
    localparam int LAT = 3 + D;
`else
    localparam int LAT = 3;
`endif
    localparam int HMAX   = 8191;
    localparam int M_IDLE = 0;
    localparam int M_UP   = 1;
    localparam int M_DOWN = 2;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] btn = '0;
    logic [2:0] current_floor = '0;
    logic       door_open = 1'b0;
    logic       emergency_stop = 1'b0;
    logic [2:0] req_floor;
    logic       req_valid;
    logic       dir_up;
    logic [7:0] pending;

    int n_checks = 0;
    int n_errors = 0;

    // Behavioural model state
    logic [7:0] raw_h [0:HMAX];
    logic [7:0] lvl_h [0:HMAX];
    int         n = 0;
    logic [7:0] m_pend = '0;
    int         m_mode = M_IDLE;
    int         m_tgt = 0;
    logic       m_valid = 1'b0;
    logic       m_dir = 1'b0;

    lift_call_queue #(.NUM_FLOORS(8), .FLOOR_W(3), .DEBOUNCE_CYCLES(D)) dut (
        .clk(clk), .reset(reset), .btn(btn), .current_floor(current_floor),
        .door_open(door_open), .emergency_stop(emergency_stop),
        .req_floor(req_floor), .req_valid(req_valid), .dir_up(dir_up), .pending(pending)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [7:0] raw_at(input int k);
        return (k < 1) ? 8'h00 : raw_h[k];
    endfunction

    function automatic logic [7:0] lvl_at(input int k);
        return (k < 1) ? 8'h00 : lvl_h[k];
    endfunction

    function automatic int clamp_floor(input int f);
        return (f > 7) ? 7 : f;
    endfunction

    // First pending floor walking away from cur in the given direction (inclusive), -1 if none.
    function automatic int scan(input logic [7:0] p, input int cur, input bit up);
        if (up) begin
            for (int f = cur; f <= 7; f++) if (p[f]) return f;
        end else begin
            for (int f = cur; f >= 0; f--) if (p[f]) return f;
        end
        return -1;
    endfunction

    task automatic eval_request(input logic [7:0] p, input int cur);
        int best, f;
        if (m_mode == M_IDLE) begin
            if (p == 8'h00) begin
                m_valid = 1'b0;
            end else begin
                best = -1;
                for (int k = 0; k < 8; k++) begin
                    if (p[k]) begin
                        if (best < 0 || (k > cur ? k - cur : cur - k) <= (best > cur ? best - cur : cur - best))
                            best = k;
                    end
                end
                m_tgt   = best;
                m_mode  = (best >= cur) ? M_UP : M_DOWN;
                m_dir   = (best >= cur);
                m_valid = 1'b1;
            end
        end else begin
            f = scan(p, cur, m_mode == M_UP);
            if (f < 0 && p != 8'h00) begin
                m_mode = (m_mode == M_UP) ? M_DOWN : M_UP;
                f = scan(p, cur, m_mode == M_UP);
            end
            if (f >= 0) begin
                m_tgt   = f;
                m_dir   = (m_mode == M_UP);
                m_valid = 1'b1;
            end else begin
                m_mode  = M_IDLE;
                m_valid = 1'b0;
            end
        end
    endtask

    task automatic model_edge();
        logic [7:0] lv, rise, clr, p_old, s;
        logic       all_diff;
        int         cur;
        n++;
        raw_h[n] = btn;
`ifdef LIFT_CALL_DEBOUNCE_EN
        lv = lvl_at(n - 1);
        for (int b = 0; b < 8; b++) begin
            all_diff = 1'b1;
            for (int k = 0; k < D; k++) begin
                s = raw_at(n - 2 - k);
                if (s[b] == lv[b]) all_diff = 1'b0;
            end
            if (all_diff) lv[b] = ~lv[b];
        end
`else
        lv = raw_at(n - 1);
`endif
        lvl_h[n] = lv;
        rise  = lvl_at(n - 1) & ~lvl_at(n - 2);
        cur   = clamp_floor(int'(current_floor));
        clr   = (door_open && !emergency_stop) ? (8'h01 << cur) : 8'h00;
        p_old = m_pend;
        if (!emergency_stop) eval_request(p_old, cur);
        m_pend = (p_old | rise) & ~clr;
    endtask

    task automatic model_reset();
        n = 0; m_pend = '0; m_mode = M_IDLE; m_tgt = 0; m_valid = 1'b0; m_dir = 1'b0;
    endtask

    task automatic check_outputs();
        check("pending", 32'(pending), 32'(m_pend));
        check("req_valid", 32'(req_valid), 32'(m_valid));
        check("dir_up", 32'(dir_up), 32'(m_dir));
        check("req_floor", 32'(req_floor), 32'(m_tgt));
    endtask

    // One clock: model the edge from the inputs in force, then compare on the falling edge.
    task automatic tick();
        @(posedge clk);
        if (reset) model_edge();
        @(negedge clk);
        check_outputs();
    endtask

    task automatic ticks(input int k);
        for (int i = 0; i < k; i++) tick();
    endtask

    // Asynchronous assertion off the clock edge, outputs checked before any edge arrives.
    task automatic do_reset();
        #2 reset = 1'b0;
        model_reset();
        #1;
        check("rst_pending", 32'(pending), 32'h0);
        check("rst_req_valid", 32'(req_valid), 32'h0);
        check("rst_req_floor", 32'(req_floor), 32'h0);
        check("rst_dir_up", 32'(dir_up), 32'h0);
        btn = '0; door_open = 1'b0; emergency_stop = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        current_floor = 3'd0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        check("init_pending", 32'(pending), 32'h0);
        check("init_req_valid", 32'(req_valid), 32'h0);
        ticks(3);

`ifdef LIFT_CALL_DEBOUNCE_EN
        // Short glitch must not be accepted
        btn = 8'h20; ticks(2);
        btn = 8'h00; ticks(10);
        check("glitch_pending", 32'(pending), 32'h0);
        check("glitch_req_valid", 32'(req_valid), 32'h0);
`endif

        // Press latency from floor 0
        do_reset();
        current_floor = 3'd0;
        btn = 8'h08;
        ticks(LAT - 1);
        check("lat_pending_early", 32'(pending), 32'h00);
        tick();
        check("lat_pending", 32'(pending), 32'h08);
        check("lat_req_valid_early", 32'(req_valid), 32'h0);
        tick();
        check("lat_req_floor", 32'(req_floor), 32'd3);
        check("lat_req_valid", 32'(req_valid), 32'h1);
        check("lat_dir_up", 32'(dir_up), 32'h1);
        ticks(10 - LAT - 1);
        btn = 8'h00; ticks(LAT + 2);

        // Distance tie from IDLE goes to the higher floor
        do_reset();
        current_floor = 3'd4;
        btn = 8'h44;
        ticks(LAT + 1);
        check("tie_req_floor", 32'(req_floor), 32'd6);
        check("tie_dir_up", 32'(dir_up), 32'h1);
        btn = 8'h00; ticks(LAT + 2);

        // Upward sweep retires floor 5 then turns down to floor 1
        do_reset();
        current_floor = 3'd2;
        btn = 8'h20; ticks(LAT + 1);
        btn = 8'h02; ticks(LAT + 1);
        check("sweep_pending", 32'(pending), 32'h22);
        check("sweep_req_floor", 32'(req_floor), 32'd5);
        current_floor = 3'd5; door_open = 1'b1; tick();
        door_open = 1'b0; tick();
        check("sweep_turn_floor", 32'(req_floor), 32'd1);
        check("sweep_turn_dir", 32'(dir_up), 32'h0);
        check("sweep_turn_pending", 32'(pending), 32'h02);
        btn = 8'h00; ticks(LAT + 2);

        // Emergency stop freezes selection and retirement, capture continues
        do_reset();
        current_floor = 3'd3;
        btn = 8'h20; ticks(LAT + 1);
        check("estop_pre_floor", 32'(req_floor), 32'd5);
        emergency_stop = 1'b1; current_floor = 3'd5; door_open = 1'b1; btn = 8'h80;
        ticks(LAT + 2);
        check("estop_pending", 32'(pending), 32'hA0);
        check("estop_req_floor", 32'(req_floor), 32'd5);
        emergency_stop = 1'b0; tick();
        check("estop_release_pending", 32'(pending), 32'h80);
        door_open = 1'b0; tick();
        check("estop_release_floor", 32'(req_floor), 32'd7);
        btn = 8'h00; ticks(LAT + 2);

        // Mid-sweep asynchronous reset with 0xA4 pending
        do_reset();
        current_floor = 3'd0;
        btn = 8'hA4; ticks(LAT + 1);
        check("pre_reset_pending", 32'(pending), 32'hA4);
        ticks(2);
        do_reset();

        // Randomized traffic against the model
        for (int c = 0; c < 3000; c++) begin
            for (int b = 0; b < 8; b++) if ($urandom_range(5) == 0) btn[b] = ~btn[b];
            door_open = ($urandom_range(3) == 0);
            if ($urandom_range(2) == 0) begin
                if ($urandom_range(1) == 0) begin
                    if (current_floor != 3'd7) current_floor = current_floor + 3'd1;
                end else if (current_floor != 3'd0) begin
                    current_floor = current_floor - 3'd1;
                end
            end
            if (emergency_stop) emergency_stop = ($urandom_range(5) != 0);
            else emergency_stop = ($urandom_range(40) == 0);
            if (c == 1500) do_reset();
            tick();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
